// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared widths, NOP encoding and fetch entry type
package fetch_buffer_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: fetch-to-decode valid/ready handshake carrying {pc, instr}
interface fetch_buffer_if #(parameter int XLEN = fetch_buffer_pkg::XLEN);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  modport master (output out_valid, out_instr, out_pc, input out_ready);
  modport slave (input out_valid, out_instr, out_pc, output out_ready);
endinterface

// File: rtl/fetch_buffer_sync_fifo.sv
// sync_fifo: DEPTH-entry queue with flush; count alone tells full from empty
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  // storage write; a flush suppresses the write so nothing stale survives
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally at DEPTH; flush and reset clear everything
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: PC owner feeding a decoupling queue of {pc, instr} to decode
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              XLEN       = fetch_buffer_pkg::XLEN,
  parameter int              DEPTH      = 4,
  parameter int              ROM_ADDR_W = 8,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        rom_size,
  output logic [ROM_ADDR_W-1:0]  rom_addr,
  input  logic [XLEN-1:0]        rom_rdata,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  fetch_buffer_if.master         dec,
  output logic [$clog2(DEPTH):0] count,
  output logic                   fetch_complete
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] pc;
  logic [2*XLEN-1:0] head;
  logic fetch_active, push, pop;
  // fetch runs while pc is inside both the program and the physical ROM
  always_comb begin
    fetch_active = (pc < rom_size) && (pc[XLEN-1:ROM_ADDR_W+2] == '0);
    pop = dec.out_valid && dec.out_ready;
    push = fetch_active && !redirect_valid && (count != CW'(DEPTH) || pop);
  end
  assign rom_addr       = pc[ROM_ADDR_W+1:2];
  assign dec.out_valid  = count != '0;
  assign dec.out_pc     = head[2*XLEN-1:XLEN];
  assign dec.out_instr  = head[XLEN-1:0];
  assign fetch_complete = !fetch_active && count == '0;
  // redirect outranks push; low pc bits are always forced to word alignment
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & ~XLEN'(3);
    else if (push) pc <= pc + XLEN'(4);
  end
  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({pc, rom_rdata}),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks against a queue-based fetch model
module tb_fetch_buffer;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] rom_size = 0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic [2:0]  count;
  logic        fetch_complete;
  logic [31:0] rom [256];
  int          vectors = 0;
  int          miscompares = 0;
  int          q[$];
  logic [31:0] mpc = 0;

  fetch_buffer_if dec();

  fetch_buffer dut (
    .clk(clk),
    .reset(reset),
    .rom_size(rom_size),
    .rom_addr(rom_addr),
    .rom_rdata(rom_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec(dec),
    .count(count),
    .fetch_complete(fetch_complete)
  );

  always #5 clk = ~clk;
  assign rom_rdata = rom[rom_addr];

  task automatic tick();
    bit pop, push, act;
    pop  = q.size() > 0 && dec.out_ready;
    act  = mpc < rom_size && mpc < 32'd1024;
    push = act && !redirect_valid && (q.size() < 4 || pop);
    @(posedge clk);
    if (reset) begin
      q.delete();
      mpc = 0;
    end else if (redirect_valid) begin
      q.delete();
      mpc = redirect_pc & ~32'd3;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(int'(mpc));
        mpc = mpc + 4;
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] size);
    rom_size = size;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    dec.out_ready = 0;
    do_reset(32'd12);
    tick();
    do_reset(32'd12);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (dec.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", dec.out_valid); end
    vectors++; if (fetch_complete !== 1'b0) begin miscompares++; $display("FAIL reset_complete: got %b want 0", fetch_complete); end
    vectors++; if (rom_addr !== 8'd0) begin miscompares++; $display("FAIL reset_pc: got %0d want 0", rom_addr); end
  endtask

  task automatic test_sequence();
    do_reset(32'd12);
    dec.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 32'(i*4)) begin miscompares++; $display("FAIL seq_pc%0d: got v=%b pc=%h want pc=%h", i, dec.out_valid, dec.out_pc, i*4); end
      vectors++; if (dec.out_instr !== rom[i]) begin miscompares++; $display("FAIL seq_instr%0d: got %h want %h", i, dec.out_instr, rom[i]); end
      vectors++; if (fetch_complete !== 1'b0) begin miscompares++; $display("FAIL seq_early_complete%0d: got %b want 0", i, fetch_complete); end
    end
    tick();
    vectors++; if (fetch_complete !== 1'b1 || dec.out_valid !== 1'b0) begin miscompares++; $display("FAIL seq_complete: got c=%b v=%b want c=1 v=0", fetch_complete, dec.out_valid); end
  endtask

  task automatic test_backpressure();
    dec.out_ready = 0;
    do_reset(32'd64);
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++; if (count !== 3'(i > 4 ? 4 : i)) begin miscompares++; $display("FAIL bp_count%0d: got %0d want %0d", i, count, i > 4 ? 4 : i); end
    end
    vectors++; if (rom_addr !== 8'd4) begin miscompares++; $display("FAIL bp_pc_hold: got word %0d want 4", rom_addr); end
    dec.out_ready = 1;
    tick();
    dec.out_ready = 0;
    vectors++; if (count !== 3'd4 || dec.out_pc !== 32'd4) begin miscompares++; $display("FAIL bp_pushpop: got count=%0d pc=%h want 4/4", count, dec.out_pc); end
    vectors++; if (rom_addr !== 8'd5) begin miscompares++; $display("FAIL bp_pc_adv: got word %0d want 5", rom_addr); end
  endtask

  task automatic test_redirect();
    dec.out_ready = 0;
    do_reset(32'd64);
    repeat (4) tick();
    redirect_valid = 1;
    redirect_pc = 32'h22;
    dec.out_ready = 1;
    tick();
    redirect_valid = 0;
    dec.out_ready = 0;
    vectors++; if (count !== 3'd0 || dec.out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got count=%0d v=%b want 0/0", count, dec.out_valid); end
    vectors++; if (rom_addr !== 8'h08) begin miscompares++; $display("FAIL redir_pc: got word %h want 08", rom_addr); end
    tick();
    vectors++; if (dec.out_pc !== 32'h20 || count !== 3'd1) begin miscompares++; $display("FAIL redir_head: got pc=%h count=%0d want 20/1", dec.out_pc, count); end
    vectors++; if (dec.out_instr !== rom[8]) begin miscompares++; $display("FAIL redir_instr: got %h want %h", dec.out_instr, rom[8]); end
  endtask

  task automatic test_rom_empty();
    dec.out_ready = 1;
    do_reset(32'd0);
    repeat (3) tick();
    vectors++; if (dec.out_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL empty_nopush: got v=%b count=%0d want 0/0", dec.out_valid, count); end
    vectors++; if (fetch_complete !== 1'b1) begin miscompares++; $display("FAIL empty_complete: got %b want 1", fetch_complete); end
    rom_size = 32'd8;
    tick();
    vectors++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 32'd0) begin miscompares++; $display("FAIL raise_pc0: got v=%b pc=%h want 1/0", dec.out_valid, dec.out_pc); end
    tick();
    vectors++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 32'd4) begin miscompares++; $display("FAIL raise_pc4: got v=%b pc=%h want 1/4", dec.out_valid, dec.out_pc); end
    tick();
    vectors++; if (dec.out_valid !== 1'b0 || fetch_complete !== 1'b1) begin miscompares++; $display("FAIL raise_done: got v=%b c=%b want 0/1", dec.out_valid, fetch_complete); end
  endtask

  task automatic test_mid_reset();
    dec.out_ready = 0;
    do_reset(32'd64);
    repeat (3) tick();
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL midrst_fill: got %0d want 3", count); end
    do_reset(32'd64);
    vectors++; if (count !== 3'd0 || dec.out_valid !== 1'b0 || rom_addr !== 8'd0) begin miscompares++; $display("FAIL midrst_clear: got count=%0d v=%b word=%0d want 0/0/0", count, dec.out_valid, rom_addr); end
    tick();
    vectors++; if (dec.out_pc !== 32'd0 || count !== 3'd1) begin miscompares++; $display("FAIL midrst_restart: got pc=%h count=%0d want 0/1", dec.out_pc, count); end
  endtask

  task automatic test_random();
    int next_pc;
    int seen;
    next_pc = 0;
    seen = 0;
    do_reset(32'd1024);
    for (int c = 0; c < 1000; c++) begin
      dec.out_ready = 1'($urandom_range(0, 1));
      #1;
      vectors++; if (count !== 3'(q.size()) || dec.out_valid !== (q.size() > 0)) begin miscompares++; $display("FAIL rand_count@%0d: got count=%0d v=%b want %0d", c, count, dec.out_valid, q.size()); end
      if (dec.out_valid && dec.out_ready) begin
        vectors++; if (dec.out_pc !== 32'(next_pc)) begin miscompares++; $display("FAIL rand_order@%0d: got pc=%h want %h", c, dec.out_pc, next_pc); end
        vectors++; if (dec.out_instr !== rom[dec.out_pc[9:2]]) begin miscompares++; $display("FAIL rand_instr@%0d: got %h want %h", c, dec.out_instr, rom[dec.out_pc[9:2]]); end
        next_pc = next_pc + 4;
        seen++;
      end
      tick();
    end
    vectors++; if (seen !== 256) begin miscompares++; $display("FAIL rand_all_words: got %0d want 256", seen); end
    vectors++; if (fetch_complete !== 1'b1) begin miscompares++; $display("FAIL rand_complete: got %b want 1", fetch_complete); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    dec.out_ready = 0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect();
    test_rom_empty();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
